// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : capture_ctrl
// Description : Single-shot scope acquisition sequencer. It pre-fills a circular
//               sample RAM, waits for a trigger, captures the post-trigger
//               samples, then freezes the buffer for the Pi to read.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ctrl #(
    parameter int DEPTH        = 25000,
    parameter int ADDR_W       = 15,
    parameter int PRE          = 1024,
    parameter int AUTO_TIMEOUT = 20000
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        sample_data,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    input  logic              auto_mode,
    input  logic              pi_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] start_addr,
    output logic              pi_signal_flag,
    output logic              busy
);

    localparam int c_cnt_max = (DEPTH > AUTO_TIMEOUT) ? DEPTH : AUTO_TIMEOUT;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_pre_last  = c_cnt_w'(PRE - 1);
    localparam logic [c_cnt_w-1:0] c_auto_last = c_cnt_w'(AUTO_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_post_len  = c_cnt_w'(DEPTH - PRE);
    localparam logic [ADDR_W-1:0]  c_addr_last = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0]  c_pre_a     = ADDR_W'(PRE);
    localparam logic [ADDR_W-1:0]  c_wrap_a    = ADDR_W'(DEPTH - PRE);

    typedef enum logic [1:0] {
        PREFILL   = 2'd0,
        WAIT_TRIG = 2'd1,
        POST      = 2'd2,
        READY     = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_waddr;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [7:0]          r_prev;
    logic                r_done_s1;
    logic                r_done_s2;
    logic                r_done_d;

    logic                w_rise;
    logic                w_fall;
    logic                w_hit;
    logic                w_auto;
    logic                w_post_done;
    logic                w_write;
    logic                w_done_rise;
    logic [ADDR_W-1:0]   w_next_waddr;

    assign w_rise       = (r_prev < trig_level) && (sample_data >= trig_level);
    assign w_fall       = (r_prev > trig_level) && (sample_data <= trig_level);
    assign w_hit        = trig_slope ? w_fall : w_rise;
    assign w_auto       = auto_mode && (r_cnt == c_auto_last);
    assign w_post_done  = (r_state == POST) && (r_cnt == c_post_len);
    // The sample arriving on the POST->READY cycle is dropped, never written.
    assign w_write      = sample_valid && (r_state != READY) && !w_post_done;
    assign w_done_rise  = r_done_s2 && !r_done_d;
    assign w_next_waddr = (r_waddr == c_addr_last) ? '0 : r_waddr + ADDR_W'(1);

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            r_state        <= PREFILL;
            r_cnt          <= '0;
            r_waddr        <= '0;
            r_trig_addr    <= '0;
            r_prev         <= '0;
            r_done_s1      <= 1'b0;
            r_done_s2      <= 1'b0;
            r_done_d       <= 1'b0;
            mem_we         <= 1'b0;
            mem_waddr      <= '0;
            mem_wdata      <= '0;
            start_addr     <= '0;
            pi_signal_flag <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_done_s1 <= pi_done;
            r_done_s2 <= r_done_s1;
            r_done_d  <= r_done_s2;

            mem_we <= w_write;
            if (w_write) begin
                mem_waddr <= r_waddr;
                mem_wdata <= sample_data;
                r_prev    <= sample_data;
                r_waddr   <= w_next_waddr;
            end

            case (r_state)
                PREFILL: begin
                    busy <= 1'b1;
                    if (sample_valid) begin
                        if (r_cnt == c_pre_last) begin
                            r_cnt   <= '0;
                            r_state <= WAIT_TRIG;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                WAIT_TRIG: begin
                    busy <= 1'b1;
                    if (sample_valid) begin
                        if (w_hit || w_auto) begin
                            r_trig_addr <= r_waddr;
                            r_cnt       <= c_cnt_w'(1);
                            r_state     <= POST;
                        end else begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                POST: begin
                    if (w_post_done) begin
                        busy           <= 1'b0;
                        pi_signal_flag <= 1'b1;
                        // Oldest kept sample sits PRE slots behind the trigger, modulo DEPTH.
                        start_addr     <= (r_trig_addr >= c_pre_a) ? r_trig_addr - c_pre_a
                                                                   : r_trig_addr + c_wrap_a;
                        r_state        <= READY;
                    end else begin
                        busy <= 1'b1;
                        if (sample_valid) begin
                            r_cnt <= r_cnt + c_cnt_w'(1);
                        end
                    end
                end
                READY: begin
                    if (w_done_rise) begin
                        pi_signal_flag <= 1'b0;
                        busy           <= 1'b1;
                        r_cnt          <= '0;
                        r_waddr        <= '0;
                        r_prev         <= '0;
                        r_state        <= PREFILL;
                    end
                end
                default: r_state <= PREFILL;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_ctrl
// Description : Directed bench for capture_ctrl; expected RAM writes are queued
//               as samples are driven and matched against each mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_capture_ctrl;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = 4;
    localparam int PRE          = 4;
    localparam int AUTO_TIMEOUT = 32;

    logic              osc_clk      = 1'b0;
    logic              reset        = 1'b1;
    logic              sample_valid = 1'b0;
    logic [7:0]        sample_data  = '0;
    logic [7:0]        trig_level   = '0;
    logic              trig_slope   = 1'b0;
    logic              auto_mode    = 1'b0;
    logic              pi_done      = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W-1:0] start_addr;
    logic              pi_signal_flag;
    logic              busy;

    capture_ctrl #(
        .DEPTH        (DEPTH),
        .ADDR_W       (ADDR_W),
        .PRE          (PRE),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .osc_clk        (osc_clk),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .trig_level     (trig_level),
        .trig_slope     (trig_slope),
        .auto_mode      (auto_mode),
        .pi_done        (pi_done),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .mem_wdata      (mem_wdata),
        .start_addr     (start_addr),
        .pi_signal_flag (pi_signal_flag),
        .busy           (busy)
    );

    always #5 osc_clk = ~osc_clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    wr_t               sb[$];
    int                n_vec  = 0;
    int                n_err  = 0;
    int                wr_cnt = 0;
    logic [ADDR_W-1:0] exp_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every observed write must match the oldest outstanding expected write.
    always @(negedge osc_clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_write: observed addr %0d data %0d expected no write",
                       mem_waddr, mem_wdata);
            end
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                n_vec++;
                assert ({mem_waddr, mem_wdata} === {e.addr, e.data}) else begin
                    n_err++;
                    $error("FAIL write: observed addr %0d data %0d expected addr %0d data %0d",
                           mem_waddr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    // Returns #1 after the edge that captured the sample, when its write is visible.
    task automatic send(input logic [7:0] d, input bit expect_wr, input int gap);
        wr_t e;
        repeat (gap) @(posedge osc_clk);
        @(posedge osc_clk); #1;
        sample_valid = 1'b1;
        sample_data  = d;
        if (expect_wr) begin
            e.addr = exp_addr;
            e.data = d;
            sb.push_back(e);
            exp_addr = (exp_addr == ADDR_W'(DEPTH - 1)) ? '0 : exp_addr + 1'b1;
        end
        @(posedge osc_clk); #1;
        sample_valid = 1'b0;
    endtask

    task automatic check_ready(input string tag, input logic [ADDR_W-1:0] exp_start);
        check({tag, "_flag_before"}, pi_signal_flag, 0);
        @(posedge osc_clk); #1;
        check({tag, "_flag"}, pi_signal_flag, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_start"}, start_addr, exp_start);
    endtask

    task automatic rearm(input string tag);
        @(posedge osc_clk); #1;
        pi_done = 1'b1;
        repeat (2) @(posedge osc_clk);
        #1;
        check({tag, "_flag_hold"}, pi_signal_flag, 1);
        @(posedge osc_clk); #1;
        check({tag, "_flag_drop"}, pi_signal_flag, 0);
        check({tag, "_busy_rearm"}, busy, 1);
        repeat (2) @(posedge osc_clk);
        #1;
        pi_done  = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        // 1: reset behaviour
        trig_level = 8'd100;
        trig_slope = 1'b0;
        #12;
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_flag", pi_signal_flag, 0);
        @(posedge osc_clk); #1;
        reset = 1'b0;
        check("rel_busy0", busy, 0);
        @(posedge osc_clk); #1;
        check("rel_busy1", busy, 1);
        for (int i = 0; i < 6; i++) send(8'(i), 1'b1, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", mem_we, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_waddr", mem_waddr, 0);
        check("mid_rst_wdata", mem_wdata, 0);
        sb.delete();
        exp_addr = '0;
        @(posedge osc_clk); #1;
        reset = 1'b0;
        @(posedge osc_clk); #1;
        check("rel2_busy", busy, 1);

        // 2: rising ramp, level 100
        for (int i = 0; i < 112; i++) begin
            send(8'(i), 1'b1, 2);
            if (i == 0) check("first_waddr", mem_waddr, 0);
        end
        check("t2_last_addr", mem_waddr, 15);
        check_ready("t2", 4'd0);
        for (int i = 0; i < 3; i++) send(8'd200, 1'b0, 2);

        // 3: falling ramp, level 50, pi_done pulse during POST
        trig_slope = 1'b1;
        trig_level = 8'd50;
        rearm("t5a");
        for (int k = 0; k <= 205; k++) send(8'(255 - k), 1'b1, 2);
        wr_cnt = 0;
        check("t3_trig_addr", mem_waddr, 13);
        for (int k = 206; k <= 208; k++) send(8'(255 - k), 1'b1, 2);
        pi_done = 1'b1;
        repeat (4) @(posedge osc_clk);
        #1;
        pi_done = 1'b0;
        repeat (4) @(posedge osc_clk);
        #1;
        check("t5_post_flag", pi_signal_flag, 0);
        check("t5_post_busy", busy, 1);
        for (int k = 209; k <= 216; k++) send(8'(255 - k), 1'b1, 2);
        check_ready("t3", 4'd9);
        check("t3_post_writes", wr_cnt, 12);
        for (int i = 0; i < 4; i++) send(8'd7, 1'b0, 1);
        @(negedge osc_clk); #1;
        check("t5_no_ready_writes", wr_cnt, 12);

        // 4: auto trigger on constant data
        trig_slope = 1'b0;
        trig_level = 8'd100;
        auto_mode  = 1'b1;
        rearm("t5b");
        for (int i = 0; i < 36; i++) send(8'd20, 1'b1, 0);
        check("t4_trig_addr", mem_waddr, 3);
        for (int i = 0; i < 11; i++) send(8'd20, 1'b1, 0);
        check_ready("t4", 4'd15);
        auto_mode = 1'b0;
        rearm("t4b");
        for (int i = 0; i < 1004; i++) send(8'd20, 1'b1, 0);
        @(negedge osc_clk); #1;
        check("t4_noauto_flag", pi_signal_flag, 0);
        check("t4_noauto_busy", busy, 1);

        // 6: trigger sample lands on the last address
        reset = 1'b1;
        #1;
        check("t6_rst_busy", busy, 0);
        sb.delete();
        exp_addr   = '0;
        trig_level = 8'd15;
        @(posedge osc_clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1);
        check("t6_trig_addr", mem_waddr, 15);
        send(8'd16, 1'b1, 1);
        check("t6_wrap_addr", mem_waddr, 0);
        for (int i = 17; i < 27; i++) send(8'(i), 1'b1, 1);
        check_ready("t6", 4'd11);

        @(negedge osc_clk); #1;
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
